lc3_pipe_controller: RTL and testbench

LC3_PIPE_CONTROLLER -- requirements
Module: lc3_pipe_controller

---
 rtl/lc3_pipe_controller_if.sv | 32 +++
 rtl/lc3_pipe_controller.sv | 138 +++++++++++++
 tb/tb_lc3_pipe_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lc3_pipe_controller_if.sv
// Signal bundle between the LC-3 pipeline datapath (master) and its stall/forwarding controller (slave).
interface lc3_pipe_controller_if;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;
  logic        br_taken;

  modport master (
    output complete_data, complete_instr, IR, IR_Exec, NZP, psr,
    input  enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    input  bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state, br_taken
  );

  modport slave (
    input  complete_data, complete_instr, IR, IR_Exec, NZP, psr,
    output enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback,
    output bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_state, br_taken
  );
endinterface

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline controller: memory-access FSM, branch stall counter, stage enables and operand forwarding.
// Forwarding is built only when LC3_PIPE_CONTROLLER_BYPASS_EN is defined; otherwise all bypass selects are 0.
module lc3_pipe_controller (
  input  logic clock,
  input  logic reset,
  lc3_pipe_controller_if.slave bus
);
  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_IND   = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_IDLE  = 2'd3
  } mem_state_t;

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100, OP_LEA = 4'b1110;

  mem_state_t mem_state_reg, mem_state_next;
  logic [2:0] br_count_reg, br_count_next;
  logic [1:0] warm_reg, warm_next;
  logic       exec_loaded_reg;
  logic       br_taken_reg, br_taken_next;
  logic       en_pc_reg, en_fetch_reg, en_decode_reg, en_exec_reg, en_wb_reg;
  logic       en_front_next, en_decode_next, en_exec_next, en_wb_next;
  logic       mem_free;
  logic [3:0] op_d, op_x;

  assign op_d = bus.IR[15:12];
  assign op_x = bus.IR_Exec[15:12];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_state_reg   <= MEM_IDLE;
      br_count_reg    <= 3'd0;
      warm_reg        <= 2'd0;
      exec_loaded_reg <= 1'b0;
      br_taken_reg    <= 1'b0;
      en_pc_reg       <= 1'b1;
      en_fetch_reg    <= 1'b1;
      en_decode_reg   <= 1'b0;
      en_exec_reg     <= 1'b0;
      en_wb_reg       <= 1'b0;
    end else begin
      mem_state_reg   <= mem_state_next;
      br_count_reg    <= br_count_next;
      warm_reg        <= warm_next;
      exec_loaded_reg <= en_exec_reg;
      br_taken_reg    <= br_taken_next;
      en_pc_reg       <= en_front_next;
      en_fetch_reg    <= en_front_next;
      en_decode_reg   <= en_decode_next;
      en_exec_reg     <= en_exec_next;
      en_wb_reg       <= en_wb_next;
    end
  end

  // A memory access starts only on an instruction freshly latched into execute.
  always_comb begin
    mem_state_next = mem_state_reg;
    case (mem_state_reg)
      MEM_IDLE: begin
        if (exec_loaded_reg) begin
          case (op_x)
            OP_LD, OP_LDR:  mem_state_next = MEM_READ;
            OP_ST, OP_STR:  mem_state_next = MEM_WRITE;
            OP_LDI, OP_STI: mem_state_next = MEM_IND;
            default:        mem_state_next = MEM_IDLE;
          endcase
        end
      end
      MEM_IND: begin
        if (bus.complete_data)
          mem_state_next = (op_x == OP_STI) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ, MEM_WRITE: begin
        if (bus.complete_data)
          mem_state_next = MEM_IDLE;
      end
      default: mem_state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    warm_next = (warm_reg == 2'd3) ? warm_reg : warm_reg + 2'd1;

    br_count_next = br_count_reg;
    if (en_decode_reg && (op_d == OP_BR || op_d == OP_JMP))
      br_count_next = 3'd4;
    else if (br_count_reg != 3'd0)
      br_count_next = br_count_reg - 3'd1;

    // Enables are registered, so they are derived from the state the next cycle will be in.
    mem_free       = (mem_state_next == MEM_IDLE);
    en_front_next  = mem_free && (br_count_next == 3'd0) && bus.complete_instr;
    en_decode_next = mem_free && (warm_next != 2'd0);
    en_exec_next   = mem_free && warm_next[1];
    en_wb_next     = (warm_next == 2'd3) &&
                     ((mem_state_reg == MEM_IDLE) ? mem_free
                                                  : (mem_state_reg == MEM_READ && bus.complete_data));

    br_taken_next = (br_count_next == 3'd2) &&
                    ((op_x == OP_JMP) || (op_x == OP_BR && (bus.NZP & bus.psr) != 3'd0));
  end

  assign bus.mem_state        = mem_state_reg;
  assign bus.br_taken         = br_taken_reg;
  assign bus.enable_updatePC  = en_pc_reg;
  assign bus.enable_fetch     = en_fetch_reg;
  assign bus.enable_decode    = en_decode_reg;
  assign bus.enable_execute   = en_exec_reg;
  assign bus.enable_writeback = en_wb_reg;

`ifdef LC3_PIPE_CONTROLLER_BYPASS_EN
  logic ir_alu, ir_src1_class, ex_alu_lea, ex_load, src1_hit, src2_hit;

  assign ir_alu        = (op_d == OP_ADD) || (op_d == OP_AND) || (op_d == OP_NOT);
  assign ir_src1_class = ir_alu || (op_d == OP_ST) || (op_d == OP_STR) || (op_d == OP_STI);
  assign ex_alu_lea    = (op_x == OP_ADD) || (op_x == OP_AND) || (op_x == OP_NOT) || (op_x == OP_LEA);
  assign ex_load       = (op_x == OP_LD) || (op_x == OP_LDR) || (op_x == OP_LDI);
  // Second source only exists in register mode (IR[5] clear).
  assign src1_hit      = ir_src1_class && (bus.IR_Exec[11:9] == bus.IR[8:6]);
  assign src2_hit      = ir_alu && !bus.IR[5] && (bus.IR_Exec[11:9] == bus.IR[2:0]);

  assign bus.bypass_alu_1 = ex_alu_lea && src1_hit;
  assign bus.bypass_alu_2 = ex_alu_lea && src2_hit;
  assign bus.bypass_mem_1 = ex_load && src1_hit;
  assign bus.bypass_mem_2 = ex_load && src2_hit;
`else
  assign bus.bypass_alu_1 = 1'b0;
  assign bus.bypass_alu_2 = 1'b0;
  assign bus.bypass_mem_1 = 1'b0;
  assign bus.bypass_mem_2 = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.IR, bus.IR_Exec};
endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed-vector bench for lc3_pipe_controller: reset, startup, memory FSM, branch stall, forwarding.
module tb_lc3_pipe_controller;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fails;

  lc3_pipe_controller_if bus ();

  lc3_pipe_controller dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

`ifdef LC3_PIPE_CONTROLLER_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packed order: updatePC, fetch, decode, execute, writeback
  function automatic logic [4:0] enables();
    return {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
            bus.enable_execute, bus.enable_writeback};
  endfunction

  task automatic run_branch(input logic [15:0] ir_exec, input logic [2:0] nzp,
                            input logic [2:0] flags, input logic taken);
    bus.IR      = 16'h0E02;
    bus.IR_Exec = ir_exec;
    bus.NZP     = nzp;
    bus.psr     = flags;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) bus.IR = 16'h1000;
      check($sformatf("br%0h_fetch_c%0d", ir_exec, i), {15'd0, bus.enable_fetch}, {15'd0, i == 4});
      check($sformatf("br%0h_pc_c%0d", ir_exec, i), {15'd0, bus.enable_updatePC}, {15'd0, i == 4});
      check($sformatf("br%0h_taken_c%0d", ir_exec, i), {15'd0, bus.br_taken}, {15'd0, taken && (i == 2)});
    end
    bus.IR_Exec = 16'h1000;
  endtask

  typedef struct {
    logic [15:0] ie;
    logic [15:0] ir;
    logic [3:0]  exp;  // alu_1, alu_2, mem_1, mem_2
  } byp_vec_t;

  byp_vec_t byp_tab [7] = '{
    '{16'h1261, 16'h1441, 4'b1100},
    '{16'h1261, 16'h1443, 4'b1000},
    '{16'h1261, 16'h1461, 4'b1000},
    '{16'h2200, 16'h1441, 4'b0011},
    '{16'hE200, 16'h7040, 4'b1000},
    '{16'h6200, 16'h1442, 4'b0010},
    '{16'h3200, 16'h1441, 4'b0000}
  };

  initial begin
    n_checks = 0;
    n_fails  = 0;
    bus.complete_data  = 1'b0;
    bus.complete_instr = 1'b1;
    bus.IR      = 16'h1000;
    bus.IR_Exec = 16'h1000;
    bus.NZP     = 3'b000;
    bus.psr     = 3'b000;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_enables", {11'd0, enables()}, 16'b11000);
    check("rst_mem_state", {14'd0, bus.mem_state}, 16'd3);
    check("rst_br_taken", {15'd0, bus.br_taken}, 16'd0);

    tick();
    tick();
    reset = 1'b1;
    tick();
    check("start_c1_enables", {11'd0, enables()}, 16'b11100);
    tick();
    check("start_c2_enables", {11'd0, enables()}, 16'b11110);
    tick();
    check("start_c3_enables", {11'd0, enables()}, 16'b11111);
    check("start_c3_mem_state", {14'd0, bus.mem_state}, 16'd3);
    check("start_c3_br_taken", {15'd0, bus.br_taken}, 16'd0);

    foreach (byp_tab[i]) begin
      bus.IR_Exec = byp_tab[i].ie;
      bus.IR      = byp_tab[i].ir;
      #1;
      check($sformatf("bypass_%0d", i),
            {12'd0, bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1, bus.bypass_mem_2},
            {12'd0, byp_tab[i].exp & {4{BYP}}});
    end
    bus.IR = 16'h1000;

    // LDI: indirect read, then data read, two cycles each
    bus.IR_Exec = 16'hA200;
    tick();
    check("ldi_c1_mem_state", {14'd0, bus.mem_state}, 16'd1);
    check("ldi_c1_enables", {11'd0, enables()}, 16'b00000);
    tick();
    check("ldi_c2_mem_state", {14'd0, bus.mem_state}, 16'd1);
    bus.complete_data = 1'b1;
    tick();
    bus.complete_data = 1'b0;
    check("ldi_c3_mem_state", {14'd0, bus.mem_state}, 16'd0);
    check("ldi_c3_writeback", {15'd0, bus.enable_writeback}, 16'd0);
    tick();
    check("ldi_c4_mem_state", {14'd0, bus.mem_state}, 16'd0);
    check("ldi_c4_enables", {11'd0, enables()}, 16'b00000);
    bus.complete_data = 1'b1;
    tick();
    bus.complete_data = 1'b0;
    bus.IR_Exec = 16'h1000;
    check("ldi_exit_mem_state", {14'd0, bus.mem_state}, 16'd3);
    check("ldi_exit_enables", {11'd0, enables()}, 16'b11111);
    tick();
    check("ldi_after_mem_state", {14'd0, bus.mem_state}, 16'd3);

    run_branch(16'h0E02, 3'b111, 3'b010, 1'b1);
    run_branch(16'h0802, 3'b100, 3'b001, 1'b0);
    run_branch(16'hC1C0, 3'b000, 3'b000, 1'b1);

    bus.complete_instr = 1'b0;
    tick();
    check("ci_low_enables", {11'd0, enables()}, 16'b00111);
    bus.complete_instr = 1'b1;
    tick();
    check("ci_high_enables", {11'd0, enables()}, 16'b11111);

    // Store, then reset in the middle of it
    bus.IR_Exec = 16'h3200;
    tick();
    check("st_mem_state", {14'd0, bus.mem_state}, 16'd2);
    check("st_enables", {11'd0, enables()}, 16'b00000);
    bus.IR_Exec = 16'h1000;
    bus.complete_data = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_state", {14'd0, bus.mem_state}, 16'd3);
    check("midrst_enables", {11'd0, enables()}, 16'b11000);
    tick();
    check("midrst_hold_enables", {11'd0, enables()}, 16'b11000);
    bus.complete_data = 1'b0;
    reset = 1'b1;
    tick();
    check("rerun_c1_enables", {11'd0, enables()}, 16'b11100);
    check("rerun_c1_mem_state", {14'd0, bus.mem_state}, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
